// File: rtl/uart_pkg.sv
// Shared UART definitions: bit-period helper, frame FSM encodings and idle line level.
// Build option UART_WORD_TX_PARITY_EN adds the PARITY state to the frame FSM.
package uart_pkg;

  localparam logic UART_IDLE_LEVEL = 1'b1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
`ifdef UART_WORD_TX_PARITY_EN
    PARITY = 3'd3,
`endif
    STOP   = 3'd4
  } uart_state_e;

  function automatic int cycles_per_bit(input int clk_hz, input int bit_rate);
    return clk_hz / bit_rate;
  endfunction

  function automatic logic even_parity(input logic [7:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// Single-frame UART serialiser: start, 8 data bits LSB first, optional parity, stop period.
// Build option UART_WORD_TX_PARITY_EN inserts an even-parity bit after data bit 7.
module uart_tx_byte
  import uart_pkg::*;
#(
  parameter int CYCLES_PER_BIT = 5208,
  parameter int STOP_BITS      = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       byte_valid_i,
  input  logic [7:0] byte_data_i,
  output logic       byte_ready_o,
  output logic       stop_pre_o,
  output logic       txd_o
);

  localparam int STOP_CYC = STOP_BITS * CYCLES_PER_BIT;
  localparam int CNT_W    = $clog2(STOP_CYC + 1);
  localparam logic [CNT_W-1:0] BIT_END  = CNT_W'(CYCLES_PER_BIT - 1);
  localparam logic [CNT_W-1:0] STOP_END = CNT_W'(STOP_CYC - 1);
  localparam logic [CNT_W-1:0] STOP_PRE = CNT_W'(STOP_CYC - 2);

  uart_state_e      state_q, state_d;
  logic [CNT_W-1:0] cyc_q, cyc_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             txd_q, txd_d;
`ifdef UART_WORD_TX_PARITY_EN
  logic             par_q, par_d;
`endif
  logic             bit_end_s, stop_end_s;

  assign bit_end_s    = (cyc_q == BIT_END);
  assign stop_end_s   = (state_q == STOP) && (cyc_q == STOP_END);
  // A new frame may be loaded on the last stop cycle so frames run back to back.
  assign byte_ready_o = (state_q == IDLE) || stop_end_s;
  assign stop_pre_o   = (state_q == STOP) && (cyc_q == STOP_PRE);
  assign txd_o        = txd_q;

  // Frame sequencing and next line level.
  always_comb begin
    state_d = state_q;
    cyc_d   = '0;
    bit_d   = bit_q;
    shift_d = shift_q;
    txd_d   = txd_q;
`ifdef UART_WORD_TX_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      IDLE: begin
        txd_d = UART_IDLE_LEVEL;
        if (byte_valid_i) begin
          state_d = START;
          txd_d   = 1'b0;
          shift_d = byte_data_i;
`ifdef UART_WORD_TX_PARITY_EN
          par_d   = even_parity(byte_data_i);
`endif
        end else begin
          state_d = IDLE;
        end
      end
      START: begin
        if (bit_end_s) begin
          state_d = DATA;
          bit_d   = 3'd0;
          txd_d   = shift_q[0];
          shift_d = {1'b0, shift_q[7:1]};
        end else begin
          cyc_d = cyc_q + CNT_W'(1);
        end
      end
      DATA: begin
        if (!bit_end_s) begin
          cyc_d = cyc_q + CNT_W'(1);
        end else if (bit_q != 3'd7) begin
          bit_d   = bit_q + 3'd1;
          txd_d   = shift_q[0];
          shift_d = {1'b0, shift_q[7:1]};
        end else begin
`ifdef UART_WORD_TX_PARITY_EN
          state_d = PARITY;
          txd_d   = par_q;
`else
          state_d = STOP;
          txd_d   = UART_IDLE_LEVEL;
`endif
        end
      end
`ifdef UART_WORD_TX_PARITY_EN
      PARITY: begin
        if (bit_end_s) begin
          state_d = STOP;
          txd_d   = UART_IDLE_LEVEL;
        end else begin
          cyc_d = cyc_q + CNT_W'(1);
        end
      end
`endif
      STOP: begin
        if (!stop_end_s) begin
          cyc_d = cyc_q + CNT_W'(1);
        end else if (byte_valid_i) begin
          state_d = START;
          txd_d   = 1'b0;
          shift_d = byte_data_i;
`ifdef UART_WORD_TX_PARITY_EN
          par_d   = even_parity(byte_data_i);
`endif
        end else begin
          state_d = IDLE;
          txd_d   = UART_IDLE_LEVEL;
        end
      end
      default: begin
        state_d = IDLE;
        txd_d   = UART_IDLE_LEVEL;
      end
    endcase
  end

  // Frame state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cyc_q   <= '0;
      bit_q   <= 3'd0;
      shift_q <= 8'h00;
      txd_q   <= UART_IDLE_LEVEL;
`ifdef UART_WORD_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      txd_q   <= txd_d;
`ifdef UART_WORD_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

endmodule

// File: rtl/uart_word_tx.sv
// Word-level UART transmitter: accepts a 32-bit word and sends it as BYTES_PER_WORD frames, LSB byte first.
// Build option UART_WORD_TX_PARITY_EN (handled in uart_tx_byte) adds an even-parity bit per frame.
module uart_word_tx
  import uart_pkg::*;
#(
  parameter int BIT_RATE       = 9600,
  parameter int CLK_HZ         = 50000000,
  parameter int STOP_BITS      = 1,
  parameter int BYTES_PER_WORD = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        uart_tx_en,
  input  logic        word_valid,
  input  logic [31:0] word_data,
  output logic        word_ready,
  output logic        uart_txd,
  output logic        uart_tx_busy,
  output logic        word_done
);

  localparam int CPB    = cycles_per_bit(CLK_HZ, BIT_RATE);
  localparam int BCNT_W = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
  localparam logic [BCNT_W-1:0] LAST_BYTE = BCNT_W'(BYTES_PER_WORD - 1);

  logic              word_ready_q, word_ready_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [31:0]       word_q, word_d;
  logic [BCNT_W-1:0] byte_cnt_q, byte_cnt_d;
  logic              xfer_s, last_byte_s;
  logic              byte_valid_s, byte_ready_s, stop_pre_s;
  logic [7:0]        byte_data_s;

  assign xfer_s      = word_valid && word_ready_q;
  assign last_byte_s = (byte_cnt_q == LAST_BYTE);

  uart_tx_byte #(
    .CYCLES_PER_BIT(CPB),
    .STOP_BITS     (STOP_BITS)
  ) u_byte (
    .clk         (clk),
    .rst         (rst),
    .byte_valid_i(byte_valid_s),
    .byte_data_i (byte_data_s),
    .byte_ready_o(byte_ready_s),
    .stop_pre_o  (stop_pre_s),
    .txd_o       (uart_txd)
  );

  // Word handshake, byte feeding and completion pulse.
  always_comb begin
    busy_d       = busy_q;
    byte_cnt_d   = byte_cnt_q;
    word_d       = word_q;
    byte_valid_s = 1'b0;
    byte_data_s  = word_q[7:0];
    done_d       = 1'b0;
    if (!busy_q) begin
      if (xfer_s) begin
        busy_d       = 1'b1;
        byte_cnt_d   = '0;
        byte_valid_s = 1'b1;
        byte_data_s  = word_data[7:0];
        word_d       = {8'h00, word_data[31:8]};
      end else begin
        byte_cnt_d = '0;
      end
    end else begin
      // word_done is registered, so it is armed one cycle before the last stop cycle.
      done_d = last_byte_s && stop_pre_s;
      if (byte_ready_s && last_byte_s) begin
        busy_d     = 1'b0;
        byte_cnt_d = '0;
      end else if (byte_ready_s) begin
        byte_cnt_d   = byte_cnt_q + BCNT_W'(1);
        byte_valid_s = 1'b1;
        word_d       = {8'h00, word_q[31:8]};
      end else begin
        busy_d = 1'b1;
      end
    end
    word_ready_d = uart_tx_en && !busy_d;
  end

  // Word-level registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      word_ready_q <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      word_q       <= 32'h0000_0000;
      byte_cnt_q   <= '0;
    end else begin
      word_ready_q <= word_ready_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      word_q       <= word_d;
      byte_cnt_q   <= byte_cnt_d;
    end
  end

  assign word_ready   = word_ready_q;
  assign uart_tx_busy = busy_q;
  assign word_done    = done_q;

endmodule

// File: tb/tb_uart_word_tx.sv
// Directed self-checking bench for uart_word_tx with a mid-bit sampling line decoder.
// Runs at 10 clocks per bit; honours UART_WORD_TX_PARITY_EN for frame length and parity bits.
module tb_uart_word_tx;

  localparam int CLK_HZ    = 1000;
  localparam int BIT_RATE  = 100;
  localparam int STOP_BITS = 1;
  localparam int BPW       = 4;
  localparam int CPB       = CLK_HZ / BIT_RATE;
  localparam int HALF      = CPB / 2;
`ifdef UART_WORD_TX_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int FRAME_CYC = (10 + STOP_BITS - 1 + PB) * CPB;
  localparam int WORD_CYC  = BPW * FRAME_CYC;

  logic        clk = 1'b0;
  logic        rst;
  logic        uart_tx_en;
  logic        word_valid;
  logic [31:0] word_data;
  logic        word_ready;
  logic        uart_txd;
  logic        uart_tx_busy;
  logic        word_done;

  int          n_checks = 0;
  int          n_errs   = 0;
  int          cyc      = 0;
  int          frame_err = 0;
  int          bad;
  int          hs_q[$];
  int          done_q[$];
  int          start_q[$];
  logic [7:0]  rx_q[$];
  logic        par_q[$];

  uart_word_tx #(
    .BIT_RATE      (BIT_RATE),
    .CLK_HZ        (CLK_HZ),
    .STOP_BITS     (STOP_BITS),
    .BYTES_PER_WORD(BPW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .uart_tx_en  (uart_tx_en),
    .word_valid  (word_valid),
    .word_data   (word_data),
    .word_ready  (word_ready),
    .uart_txd    (uart_txd),
    .uart_tx_busy(uart_tx_busy),
    .word_done   (word_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Handshake and completion logs, sampled mid-cycle.
  always @(negedge clk) begin
    if (word_valid && word_ready && !rst) hs_q.push_back(cyc);
    if (word_done === 1'b1) done_q.push_back(cyc);
  end

  // Line decoder: detects a start bit, then samples every bit in its middle.
  initial begin : line_decoder
    logic [7:0] rx_byte;
    logic       frame_ok;
    forever begin
      @(negedge clk);
      if (uart_txd === 1'b0) begin
        start_q.push_back(cyc);
        repeat (HALF) @(negedge clk);
        frame_ok = (uart_txd === 1'b0);
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clk);
          rx_byte[i] = uart_txd;
        end
`ifdef UART_WORD_TX_PARITY_EN
        repeat (CPB) @(negedge clk);
        par_q.push_back(uart_txd);
`endif
        for (int s = 0; s < STOP_BITS; s++) begin
          repeat (CPB) @(negedge clk);
          frame_ok = frame_ok && (uart_txd === 1'b1);
        end
        rx_q.push_back(rx_byte);
        if (!frame_ok) frame_err++;
        repeat (CPB - HALF - 1) @(negedge clk);
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_logs();
    hs_q.delete();
    done_q.delete();
    start_q.delete();
    rx_q.delete();
    par_q.delete();
    frame_err = 0;
  endtask

  // Called on a negedge; returns on the negedge after the handshake.
  task automatic send_word(input logic [31:0] w, input bit hold);
    int n = 0;
    word_data  = w;
    word_valid = 1'b1;
    while (word_ready !== 1'b1 && n < 20000) begin
      @(negedge clk);
      n++;
    end
    check("handshake_wait", (n < 20000), 1);
    @(negedge clk);
    if (!hold) word_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (word_done !== 1'b1 && n < WORD_CYC + 100) begin
      @(negedge clk);
      n++;
    end
    check("done_wait", word_done, 1);
  endtask

  task automatic check_word(input string tag, input logic [31:0] w);
    logic [7:0] b;
    for (int i = 0; i < BPW; i++) begin
      b = (rx_q.size() > 0) ? rx_q.pop_front() : 8'hxx;
      check(tag, b, w[8*i +: 8]);
    end
    check({tag, "_framing"}, frame_err, 0);
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: time limit reached, errors=%0d", n_errs);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst        = 1'b1;
    uart_tx_en = 1'b1;
    word_valid = 1'b0;
    word_data  = 32'h0000_0000;

    // Reset values and a long idle period.
    repeat (4) @(negedge clk);
    check("rst_txd", uart_txd, 1);
    check("rst_ready", word_ready, 1);
    check("rst_busy", uart_tx_busy, 0);
    check("rst_done", word_done, 0);
    rst = 1'b0;
    bad = 0;
    repeat (1000) begin
      @(negedge clk);
      if (uart_txd !== 1'b1 || word_ready !== 1'b1 || uart_tx_busy !== 1'b0 || word_done !== 1'b0) bad++;
    end
    check("idle_hold", bad, 0);

    // Single word: byte order, start latency, completion latency.
    clear_logs();
    send_word(32'hfe010113, 1'b0);
    check("w1_busy", uart_tx_busy, 1);
    check("w1_ready_low", word_ready, 0);
    wait_done();
    @(negedge clk);
    check("w1_ready_back", word_ready, 1);
    check("w1_idle_after", uart_tx_busy, 0);
    repeat (3) @(negedge clk);
    check_word("w1_byte", 32'hfe010113);
    check("w1_hs_count", hs_q.size(), 1);
    check("w1_done_count", done_q.size(), 1);
    check("w1_start_lat", start_q[0] - hs_q[0], 1);
    check("w1_done_lat", done_q[0] - hs_q[0], WORD_CYC);

    // Back-to-back words with word_valid held high.
    clear_logs();
    send_word(32'h00812e23, 1'b1);
    send_word(32'h02010413, 1'b0);
    wait_done();
    repeat (3) @(negedge clk);
    check("b2b_hs_count", hs_q.size(), 2);
    check("b2b_done_count", done_q.size(), 2);
    check_word("b2b_w1", 32'h00812e23);
    check_word("b2b_w2", 32'h02010413);
    check("b2b_hs_gap", hs_q[1] - done_q[0], 1);
    check("b2b_line_gap", start_q[4] - start_q[3], FRAME_CYC + 1);
    check("b2b_done2_lat", done_q[1] - hs_q[1], WORD_CYC);

    // Reset in the middle of the third frame.
    clear_logs();
    send_word(32'hfe042623, 1'b0);
    repeat (2 * FRAME_CYC + 3 * CPB) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_txd", uart_txd, 1);
    check("mid_rst_ready", word_ready, 1);
    check("mid_rst_busy", uart_tx_busy, 0);
    rst = 1'b0;
    repeat (3 * FRAME_CYC) @(negedge clk);
    check("mid_rst_no_done", done_q.size(), 0);
    check("mid_rst_frames", rx_q.size(), 3);
    check("mid_rst_byte0", rx_q[0], 8'h23);
    check("mid_rst_byte1", rx_q[1], 8'h26);
    clear_logs();
    send_word(32'h0000_0000, 1'b0);
    wait_done();
    repeat (3) @(negedge clk);
    check_word("post_rst", 32'h0000_0000);
    check("post_rst_done_lat", done_q[0] - hs_q[0], WORD_CYC);

    // Enable gating: no acceptance while disabled, in-flight word completes.
    clear_logs();
    uart_tx_en = 1'b0;
    repeat (2) @(negedge clk);
    word_data  = 32'ha5c30f81;
    word_valid = 1'b1;
    bad = 0;
    repeat (10000) begin
      @(negedge clk);
      if (word_ready !== 1'b0 || uart_txd !== 1'b1 || uart_tx_busy !== 1'b0) bad++;
    end
    check("gate_hold", bad, 0);
    check("gate_no_hs", hs_q.size(), 0);
    uart_tx_en = 1'b1;
    send_word(32'ha5c30f81, 1'b0);
    repeat (FRAME_CYC + CPB) @(negedge clk);
    uart_tx_en = 1'b0;
    wait_done();
    @(negedge clk);
    check("gate_ready_stays_low", word_ready, 0);
    repeat (3) @(negedge clk);
    check_word("gate_word", 32'ha5c30f81);
    check("gate_done_lat", done_q[0] - hs_q[0], WORD_CYC);

    // All-ones word; with parity enabled every parity bit must be 0.
    clear_logs();
    uart_tx_en = 1'b1;
    repeat (2) @(negedge clk);
    send_word(32'hffffffff, 1'b0);
    wait_done();
    repeat (3) @(negedge clk);
    check_word("ones", 32'hffffffff);
    check("ones_done_lat", done_q[0] - hs_q[0], WORD_CYC);
`ifdef UART_WORD_TX_PARITY_EN
    check("ones_parity_count", par_q.size(), 4);
    for (int i = 0; i < BPW; i++) begin
      check("ones_parity", (par_q.size() > i) ? par_q[i] : 1'bx, 1'b0);
    end
`endif

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_word_tx.md
Name: uart_word_tx

Overview:
- UART transmitter; the inverse of the instruction-load receive path.
- Accepts a 32-bit word over a valid/ready handshake and serialises it on uart_txd as four 8N1 frames, least-significant byte first. This is the same byte order the loader uses when receiving instruction words.
- Sits beside the UART receiver in the wrapper. Used to dump instruction memory and GPIO/status words back to the host.

Parameters:
- BIT_RATE, 9600: line bit rate in bits/s.
- CLK_HZ, 50000000: clk frequency in Hz.
- STOP_BITS, 1: stop bits per frame; legal values 1 or 2.
- BYTES_PER_WORD, 4: frames per accepted word; the byte counter width is derived from it.

Ports:
- clk, in, 1: system clock; the only clock.
- rst, in, 1: reset, synchronous, active-high.
- uart_tx_en, in, 1: transmit enable; gates acceptance of new words only.
- word_valid, in, 1: word_data is valid.
- word_data, in, 32: word to send; byte0 = [7:0] is sent first.
- word_ready, out, 1: block can accept a word this cycle.
- uart_txd, out, 1: serial line, idle high.
- uart_tx_busy, out, 1: a word is in flight.
- word_done, out, 1: one-cycle pulse when the last stop bit of a word completes.

Behaviour:
- Reset: one clock is synchronous and reset is synchronous active-high (rst). On any clk edge with rst=1:
  - uart_txd=1, word_ready=1, uart_tx_busy=0, word_done=0.
  - FSM goes to IDLE; bit, cycle and byte counters clear.
- Bit timing:
  - CYCLES_PER_BIT = CLK_HZ/BIT_RATE, integer division; default 5208.
  - Every start, data and parity bit is held exactly CYCLES_PER_BIT cycles.
  - The stop period is held STOP_BITS*CYCLES_PER_BIT cycles.
- word_ready = (state==IDLE) & uart_tx_en, registered.
- Handshake:
  - Transfer occurs on a rising edge with word_valid & word_ready; word_data is captured into a shift register.
  - word_ready falls on the cycle after the transfer.
  - word_data is ignored at all other times; word_valid may drop freely.
- Latency: uart_txd goes low (start bit) on the first cycle after the transfer.
- FSM states and transitions:
  - IDLE: on transfer, go to START.
  - START: go to DATA.
  - DATA: 8 bits, LSB first, then go to PARITY (when enabled) or STOP.
  - PARITY: go to STOP.
  - STOP: if byte_cnt < BYTES_PER_WORD-1, increment byte_cnt and go to START with no idle gap; otherwise go to IDLE.
- Completion:
  - On the cycle the final stop period ends, word_done pulses for 1 cycle.
  - On the following cycle, word_ready returns high if uart_tx_en=1.
- Back-to-back words: with word_valid held high, the next transfer happens on the first cycle ready is high. Line idle time between words is therefore exactly 1 cycle.
- uart_tx_en=0 mid-word: the word in flight completes normally; no new word is accepted.
- uart_tx_busy = (state != IDLE).
- Reset mid-frame: the word is discarded, uart_txd=1 on the next edge, and no word_done is issued.
- Duration of a full word: BYTES_PER_WORD*(10 + STOP_BITS-1)*CYCLES_PER_BIT cycles; 208320 at defaults.

Optional Feature:
- Macro: UART_WORD_TX_PARITY_EN.
- Defined:
  - An even-parity bit (XOR of the 8 data bits) is inserted after bit 7 of every frame, held CYCLES_PER_BIT cycles.
  - Frame length is 11 bits (STOP_BITS=1).
- Undefined:
  - No PARITY state exists; frames are 8N1.
  - No parity logic is synthesised.

Decomposition:
- Shared package uart_pkg holds:
  - the CYCLES_PER_BIT computation as a constant function of CLK_HZ and BIT_RATE, shared with the receiver;
  - FSM state encodings IDLE/START/DATA/PARITY/STOP;
  - UART_IDLE_LEVEL=1.
- Sub-module uart_tx_byte: a single-frame serialiser with byte_valid/byte_ready and its own bit/cycle counters.
- uart_word_tx owns the word register, the byte counter, the word handshake and word_done.

Test Plan:
- Idle: assert rst for 4 cycles, release, hold for 1000 cycles → uart_txd=1, word_ready=1, uart_tx_busy=0, word_done=0 throughout.
- Single word 32'hfe010113:
  - Line model samples mid-bit and decodes bytes 13,01,01,fe in order.
  - Start bit falls 1 cycle after the handshake.
  - word_done fires exactly 208320 cycles after the handshake.
- Back-to-back: word_valid held high with 32'h00812e23 then 32'h02010413 → both words decoded correctly, with exactly 1 idle-high cycle between the last stop bit and the next start bit.
- Reset during byte 2 of 32'hfe042623 → uart_txd=1 on the next cycle, word_ready=1, no word_done pulse; a following word 32'h00000000 is transmitted intact.
- Enable gating:
  - uart_tx_en=0 with word_valid=1 for 10000 cycles → word_ready=0 and line idle.
  - Raise uart_tx_en → word accepted and transmitted.
  - Drop uart_tx_en mid-word → that word still completes.
- UART_WORD_TX_PARITY_EN defined, send 32'hffffffff → each frame is 11 bits with parity=0, and word_done fires at 229152 cycles.
